// File: rtl/ni_eject.sv
// ni_eject: NoC network-interface ejection unit.
// Buffers incoming flits in per-VC FIFOs and delivers whole packets to the core over a
// valid/ready stream without interleaving. One credit pulse is returned per freed slot.
// Optional protocol checker: define NI_EJECT_PROTO_CHECK_EN.
module ni_eject #(
    parameter int unsigned NUM_VCS  = 2,
    parameter int unsigned VC_DEPTH = 4,
    parameter int unsigned FLIT_W   = 32,
    localparam int unsigned VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned CNT_W   = $clog2(VC_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_valid,
    input  logic [VC_W-1:0]    in_vc,
    input  logic               in_head,
    input  logic               in_tail,
    input  logic [FLIT_W-1:0]  in_data,
    output logic [NUM_VCS-1:0] credit_out,
    output logic               out_valid,
    output logic [VC_W-1:0]    out_vc,
    output logic               out_head,
    output logic               out_tail,
    output logic [FLIT_W-1:0]  out_data,
    input  logic               out_ready,
    output logic               overflow_err,
    output logic               proto_err
);

    localparam int unsigned PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int unsigned ENT_W = FLIT_W + 2;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    logic [ENT_W-1:0]   mem_q    [NUM_VCS][VC_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_VCS];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_VCS];
    logic [CNT_W-1:0]   cnt_q    [NUM_VCS];
    logic [NUM_VCS-1:0] empty, full, pop, wr_vec;

    state_e          state_q, state_d;
    logic [VC_W-1:0] lock_vc_q, lock_vc_d, rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0] sel_vc, cur_vc, next_vc, arb_vc;
    logic [VC_W:0]   arb_sum;
    logic            sel_found, avail, discard, pop_any;
    logic            wr_en, vc_ok, overflow_set;
    logic [ENT_W-1:0] front;
    logic            front_head, front_tail;

    logic [NUM_VCS-1:0] credit_q;
    logic               overflow_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Out-of-range VC numbers only exist when NUM_VCS is not a power of two.
    if (NUM_VCS == (1 << VC_W)) begin : g_vc_all_legal
        assign vc_ok = 1'b1;
    end else begin : g_vc_range
        assign vc_ok = (32'(in_vc) < NUM_VCS);
    end

    // Per-VC occupancy flags.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            empty[v] = (cnt_q[v] == '0);
            full[v]  = (cnt_q[v] == CNT_W'(VC_DEPTH));
        end
    end

    // Round-robin search for the first non-empty VC starting at rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        arb_sum   = '0;
        arb_vc    = '0;
        for (int unsigned i = 0; i < NUM_VCS; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (VC_W + 1)'(i);
            if (arb_sum >= (VC_W + 1)'(NUM_VCS)) begin
                arb_sum = arb_sum - (VC_W + 1)'(NUM_VCS);
            end
            arb_vc = arb_sum[VC_W-1:0];
            if (!sel_found && !empty[arb_vc]) begin
                sel_found = 1'b1;
                sel_vc    = arb_vc;
            end
        end
    end

    // Offered flit, pop decision and core-facing outputs.
    always_comb begin
        cur_vc     = (state_q == StLocked) ? lock_vc_q : sel_vc;
        front      = mem_q[cur_vc][rd_ptr_q[cur_vc]];
        front_head = front[ENT_W-1];
        front_tail = front[ENT_W-2];
        avail      = (state_q == StLocked) ? !empty[cur_vc] : sel_found;
        discard    = 1'b0;
`ifdef NI_EJECT_PROTO_CHECK_EN
        // A packet must start with a head flit; anything else is dropped at the front.
        discard    = (state_q == StIdle) && avail && !front_head;
`endif
        out_valid   = avail && !discard;
        pop_any     = discard || (out_valid && out_ready);
        pop         = '0;
        pop[cur_vc] = pop_any;
        out_vc      = out_valid ? cur_vc : '0;
        out_head    = out_valid && front_head;
        out_tail    = out_valid && front_tail;
        out_data    = out_valid ? front[FLIT_W-1:0] : '0;
    end

    // Write acceptance: a full FIFO takes a flit only when it pops in the same cycle.
    always_comb begin
        wr_en         = in_valid && vc_ok && (!full[in_vc] || pop[in_vc]);
        wr_vec        = '0;
        wr_vec[in_vc] = wr_en;
        overflow_set  = in_valid && !wr_en;
    end

    // Packet-lock FSM and round-robin pointer update.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        next_vc   = (cur_vc == VC_W'(NUM_VCS - 1)) ? '0 : cur_vc + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (pop_any) begin
                    rr_ptr_d = next_vc;
                    if (!discard && !front_tail) begin
                        state_d   = StLocked;
                        lock_vc_d = cur_vc;
                    end
                end
            end
            StLocked: begin
                if (pop_any && front_tail) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, registered credits and sticky overflow flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= StIdle;
            lock_vc_q  <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_vc_q  <= lock_vc_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= pop;
            overflow_q <= overflow_q | overflow_set;
        end
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (wr_vec[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
                if (pop[v])    rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
                if (wr_vec[v] && !pop[v]) begin
                    cnt_q[v] <= cnt_q[v] + 1'b1;
                end else if (!wr_vec[v] && pop[v]) begin
                    cnt_q[v] <= cnt_q[v] - 1'b1;
                end
            end
        end
    end

    // Flit storage; contents are qualified by the counters so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[in_vc][wr_ptr_q[in_vc]] <= {in_head, in_tail, in_data};
        end
    end

`ifdef NI_EJECT_PROTO_CHECK_EN
    logic proto_set, proto_q;
    assign proto_set = discard || ((state_q == StLocked) && pop_any && front_head);

    // Sticky protocol-error flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) proto_q <= 1'b0;
        else      proto_q <= proto_q | proto_set;
    end
    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_ni_eject.sv
// Self-checking bench for ni_eject: queue-based packet model checked every cycle,
// plus directed scenarios with hand-computed expectations.
// Honours NI_EJECT_PROTO_CHECK_EN when defined for the build.
module tb_ni_eject;

    localparam int NUM_VCS  = 2;
    localparam int VC_DEPTH = 4;
    localparam int FLIT_W   = 32;
    localparam int VC_W     = 1;
`ifdef NI_EJECT_PROTO_CHECK_EN
    localparam bit PROTO = 1'b1;
`else
    localparam bit PROTO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               arst;
    logic               in_valid, in_head, in_tail, out_ready;
    logic [VC_W-1:0]    in_vc;
    logic [FLIT_W-1:0]  in_data;
    logic [NUM_VCS-1:0] credit_out;
    logic               out_valid, out_head, out_tail, overflow_err, proto_err;
    logic [VC_W-1:0]    out_vc;
    logic [FLIT_W-1:0]  out_data;

    ni_eject #(.NUM_VCS(NUM_VCS), .VC_DEPTH(VC_DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail),
        .in_data(in_data), .credit_out(credit_out),
        .out_valid(out_valid), .out_vc(out_vc), .out_head(out_head), .out_tail(out_tail),
        .out_data(out_data), .out_ready(out_ready),
        .overflow_err(overflow_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              head;
        logic              tail;
        logic [FLIT_W-1:0] data;
    } flit_t;

    // Model state: per-VC queues, locked VC (-1 = none), next VC to search from.
    flit_t              mq[NUM_VCS][$];
    int                 m_lock = -1;
    int                 m_rr = 0;
    logic [NUM_VCS-1:0] m_cred = '0;
    logic               m_ovf = 1'b0;
    logic               m_perr = 1'b0;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [FLIT_W-1:0] delivered[$];
    int                cred_cnt[NUM_VCS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // What the core must be offered right now, from the packet rules.
    function automatic void model_offer(output bit valid, output int vc, output flit_t fl,
                                        output bit disc);
        valid = 1'b0; vc = 0; fl = '0; disc = 1'b0;
        if (m_lock >= 0) begin
            vc = m_lock;
            if (mq[vc].size() > 0) begin
                valid = 1'b1;
                fl = mq[vc][0];
            end
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                int idx = (m_rr + i) % NUM_VCS;
                if (mq[idx].size() > 0) begin
                    valid = 1'b1; vc = idx; fl = mq[idx][0];
                    break;
                end
            end
            if (valid && PROTO && !fl.head) begin
                disc = 1'b1;
                valid = 1'b0;
            end
        end
    endfunction

    // Model update on each clock edge.
    always @(posedge clk or posedge arst) begin
        bit    v_ok, disc, do_pop;
        int    vc;
        flit_t fl, popped;
        if (arst) begin
            for (int v = 0; v < NUM_VCS; v++) mq[v].delete();
            m_lock = -1; m_rr = 0; m_cred = '0; m_ovf = 1'b0; m_perr = 1'b0;
        end else begin
            model_offer(v_ok, vc, fl, disc);
            do_pop = disc || (v_ok && out_ready);
            m_cred = '0;
            if (do_pop) begin
                popped = mq[vc].pop_front();
                m_cred[vc] = 1'b1;
                if (m_lock < 0) begin
                    m_rr = (vc + 1) % NUM_VCS;
                    if (disc) m_perr = 1'b1;
                    else if (!popped.tail) m_lock = vc;
                end else begin
                    if (PROTO && popped.head) m_perr = 1'b1;
                    if (popped.tail) m_lock = -1;
                end
            end
            if (in_valid) begin
                if (int'(in_vc) >= NUM_VCS || mq[in_vc].size() >= VC_DEPTH) m_ovf = 1'b1;
                else mq[in_vc].push_back({in_head, in_tail, in_data});
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit    v;
        int    vc;
        flit_t fl;
        bit    disc;
        model_offer(v, vc, fl, disc);
        check("out_valid", 64'(out_valid), 64'(v));
        if (v) begin
            check("out_vc", 64'(out_vc), 64'(vc));
            check("out_head_tail", 64'({out_head, out_tail}), 64'({fl.head, fl.tail}));
            check("out_data", 64'(out_data), 64'(fl.data));
        end else begin
            check("idle_outs_zero", 64'({out_vc, out_head, out_tail, out_data}), 64'd0);
        end
        check("credit_out", 64'(credit_out), 64'(m_cred));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        check("proto_err", 64'(proto_err), 64'(m_perr));
        if (out_valid && out_ready) delivered.push_back(out_data);
        for (int i = 0; i < NUM_VCS; i++) cred_cnt[i] += int'(credit_out[i]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int vc, input bit h, input bit t, input logic [FLIT_W-1:0] d);
        in_valid = 1'b1; in_vc = vc[VC_W-1:0]; in_head = h; in_tail = t; in_data = d;
        step();
        in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0; in_data = '0;
    endtask

    task automatic clear_logs();
        delivered.delete();
        for (int i = 0; i < NUM_VCS; i++) cred_cnt[i] = 0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #12 arst = 1'b0;
        step();
        clear_logs();
    endtask

    initial begin
        logic [FLIT_W-1:0] exp2[6];
        exp2 = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h201, 32'h202};

        arst = 1'b1; in_valid = 1'b0; in_vc = '0; in_head = 1'b0; in_tail = 1'b0;
        in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < NUM_VCS; i++) cred_cnt[i] = 0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outs", 64'({credit_out, overflow_err, proto_err, out_data}), 64'd0);
        #9 arst = 1'b0;
        step();

        // Single-flit packet on VC0.
        send(0, 1'b1, 1'b1, 32'hA5);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_head_tail", 64'({out_head, out_tail}), 64'b11);
        check("t1_data", 64'(out_data), 64'hA5);
        step();
        check("t1_credit", 64'(credit_out), 64'b01);
        step();
        check("t1_credit_gone", 64'(credit_out), 64'd0);
        check("t1_empty", 64'(out_valid), 64'd0);

        // Two 3-flit packets interleaved on VC0/VC1.
        do_reset();
        send(0, 1'b1, 1'b0, 32'h100);
        send(1, 1'b1, 1'b0, 32'h200);
        send(0, 1'b0, 1'b0, 32'h101);
        send(1, 1'b0, 1'b0, 32'h201);
        send(0, 1'b0, 1'b1, 32'h102);
        send(1, 1'b0, 1'b1, 32'h202);
        idle(6);
        check("t2_count", 64'(delivered.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("t2_order", 64'((i < delivered.size()) ? delivered[i] : 32'hDEADBEEF),
                  64'(exp2[i]));
        end
        check("t2_credits_vc0", 64'(cred_cnt[0]), 64'd3);
        check("t2_credits_vc1", 64'(cred_cnt[1]), 64'd3);

        // Fill VC0 with the core stalled, then overflow it.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1'b1, 1'b1, 32'h300 + 32'(i));
        check("t3_no_ovf_yet", 64'(overflow_err), 64'd0);
        send(0, 1'b1, 1'b1, 32'h304);
        check("t3_ovf", 64'(overflow_err), 64'd1);
        idle(2);
        check("t3_no_credit", 64'(cred_cnt[0] + cred_cnt[1]), 64'd0);
        out_ready = 1'b1;
        idle(8);
        check("t3_delivered", 64'(delivered.size()), 64'd4);
        check("t3_last", 64'((delivered.size() == 4) ? delivered[3] : 32'hDEADBEEF), 64'h303);
        check("t3_credits", 64'(cred_cnt[0]), 64'd4);

        // Full VC1 written in the same cycle it pops.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1'b1, 1'b1, 32'h400 + 32'(i));
        out_ready = 1'b1;
        send(1, 1'b1, 1'b1, 32'h404);
        out_ready = 1'b0;
        check("t4_ovf_clear", 64'(overflow_err), 64'd0);
        send(1, 1'b1, 1'b1, 32'h405);
        check("t4_still_full", 64'(overflow_err), 64'd1);
        out_ready = 1'b1;
        idle(8);
        check("t4_delivered", 64'(delivered.size()), 64'd5);
        check("t4_last", 64'((delivered.size() == 5) ? delivered[4] : 32'hDEADBEEF), 64'h404);

        // Body flit with no packet open.
        do_reset();
        send(0, 1'b0, 1'b0, 32'h500);
`ifdef NI_EJECT_PROTO_CHECK_EN
        check("t5_not_offered", 64'(out_valid), 64'd0);
        step();
        check("t5_credit", 64'(credit_out), 64'b01);
        check("t5_proto", 64'(proto_err), 64'd1);
        idle(3);
        check("t5_one_credit", 64'(cred_cnt[0]), 64'd1);
        check("t5_no_delivery", 64'(delivered.size()), 64'd0);
`else
        check("t5_offered", 64'(out_valid), 64'd1);
        check("t5_no_proto", 64'(proto_err), 64'd0);
`endif

        // Reset while locked on VC1 with flits buffered.
        do_reset();
        send(1, 1'b1, 1'b0, 32'h600);
        step();
        out_ready = 1'b0;
        send(1, 1'b0, 1'b0, 32'h601);
        send(1, 1'b0, 1'b0, 32'h602);
        send(0, 1'b1, 1'b1, 32'h6F0);
        check("t6_locked_vc", 64'(out_vc), 64'd1);
        check("t6_body", 64'(out_data), 64'h601);
        #3 arst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_outs", 64'({out_vc, out_head, out_tail, out_data, credit_out}), 64'd0);
        #3 arst = 1'b0;
        step();
        out_ready = 1'b1;
        send(0, 1'b1, 1'b1, 32'h6A0);
        check("t6_new_valid", 64'(out_valid), 64'd1);
        check("t6_new_vc", 64'(out_vc), 64'd0);
        check("t6_new_data", 64'(out_data), 64'h6A0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
